// File: rtl/cnn_pkg.sv
// cnn_pkg: shared image/kernel geometry, FSM states and tap address helper
// Contents:
//   IMG_W, IMG_H, K, ADDR_W, DATA_W  image and memory geometry
//   NT, NP, NP_LAST                  taps per window, issue cycles per window, last issue index
//   ROW_LAST, COL_LAST               final output-grid row/column
//   state_t                          fetch FSM states
//   tap_addr()                       linear memory address of one window tap
package cnn_pkg;
    localparam int IMG_W  = 28;
    localparam int IMG_H  = 28;
    localparam int K      = 3;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam int NT     = K * K;
    localparam int NP     = (NT + 1) / 2;
    localparam logic [2:0] NP_LAST  = 3'(NP - 1);
    localparam logic [4:0] ROW_LAST = 5'(IMG_H - K);
    localparam logic [4:0] COL_LAST = 5'(IMG_W - K);

    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, PRESENT, DONE} state_t;

    // Tap t sits at kernel position (t / K, t % K) relative to the window origin.
    function automatic logic [ADDR_W-1:0] tap_addr(input logic [4:0] row, input logic [4:0] col,
                                                   input logic [3:0] t);
        return ADDR_W'((int'(row) + int'(t) / K) * IMG_W + int'(col) + int'(t) % K);
    endfunction
endpackage

// File: rtl/conv_window_fetch_if.sv
// conv_window_fetch_if: control, image-memory read and window-stream signals of the fetcher
// Signals:
//   start/busy/done                    pass control
//   mem_load, mem_addr1/2, mem_data1/2 dual-port memory read bus
//   win_valid/ready/data/row/col/last  window stream to the conv engine
// Modports: master = fetcher, slave = environment (controller, memory, conv engine)
interface conv_window_fetch_if;
    import cnn_pkg::*;
    logic                   start;
    logic                   busy;
    logic                   done;
    logic                   mem_load;
    logic [ADDR_W-1:0]      mem_addr1;
    logic [ADDR_W-1:0]      mem_addr2;
    logic [DATA_W-1:0]      mem_data1;
    logic [DATA_W-1:0]      mem_data2;
    logic                   win_valid;
    logic                   win_ready;
    logic [NT*DATA_W-1:0]   win_data;
    logic [4:0]             win_row;
    logic [4:0]             win_col;
    logic                   win_last;

    modport master (
        input  start, mem_data1, mem_data2, win_ready,
        output busy, done, mem_load, mem_addr1, mem_addr2,
               win_valid, win_data, win_row, win_col, win_last
    );
    modport slave (
        output start, mem_data1, mem_data2, win_ready,
        input  busy, done, mem_load, mem_addr1, mem_addr2,
               win_valid, win_data, win_row, win_col, win_last
    );
endinterface

// File: rtl/window_addr_gen.sv
// window_addr_gen: combinational tap-pair addresses for one issue cycle of a window
// Ports:
//   row, col  in   window origin in the output grid
//   j         in   issue (pair) index
//   addr1     out  address of tap 2j
//   addr2     out  address of tap 2j+1, or tap 2j again when that tap does not exist
//   v2        out  port-2 tap exists (its data must be kept)
module window_addr_gen
    import cnn_pkg::*;
(
    input  logic [4:0]        row,
    input  logic [4:0]        col,
    input  logic [2:0]        j,
    output logic [ADDR_W-1:0] addr1,
    output logic [ADDR_W-1:0] addr2,
    output logic              v2
);
    assign v2    = {j, 1'b1} < 4'(NT);
    assign addr1 = tap_addr(row, col, {j, 1'b0});
    assign addr2 = tap_addr(row, col, v2 ? {j, 1'b1} : {j, 1'b0});
endmodule

// File: rtl/conv_window_fetch.sv
// conv_window_fetch: walks every KxK window of the stored image and streams it to the conv engine
// Ports:
//   clk   in  clock, posedge
//   rst   in  synchronous reset, active-low
//   bus   master side of conv_window_fetch_if (control, memory reads, window stream)
module conv_window_fetch
    import cnn_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    conv_window_fetch_if.master  bus
);
    state_t            state, nxt;
    logic [4:0]        row, col;
    logic [2:0]        j, c_q;
    logic              cap_q, v2_q, v2, last, hs;
    logic [ADDR_W-1:0] a1, a2;
    logic [DATA_W-1:0] taps [NT];

    window_addr_gen u_gen (.row(row), .col(col), .j(j), .addr1(a1), .addr2(a2), .v2(v2));

    assign last = row == ROW_LAST && col == COL_LAST;
    assign hs   = state == PRESENT && bus.win_ready;

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = bus.start ? ISSUE : IDLE;
            ISSUE:   nxt = j == NP_LAST ? DRAIN : ISSUE;
            DRAIN:   nxt = PRESENT;
            PRESENT: nxt = bus.win_ready ? (last ? DONE : ISSUE) : PRESENT;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Read data arrives one cycle after its issue, so the pair index and
    // port-2 validity are delayed alongside a capture strobe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            row   <= '0;
            col   <= '0;
            j     <= '0;
            c_q   <= '0;
            cap_q <= 1'b0;
            v2_q  <= 1'b0;
            taps  <= '{default: '0};
        end else begin
            cap_q <= state == ISSUE;
            c_q   <= j;
            v2_q  <= v2;
            if (state == ISSUE) j <= j == NP_LAST ? 3'd0 : j + 3'd1;
            if (state == IDLE && bus.start) begin
                row <= '0;
                col <= '0;
                j   <= '0;
            end
            if (hs && !last) begin
                col <= col == COL_LAST ? 5'd0 : col + 5'd1;
                row <= col == COL_LAST ? row + 5'd1 : row;
            end
            if (cap_q) begin
                taps[{c_q, 1'b0}] <= bus.mem_data1;
                if (v2_q) taps[{c_q, 1'b1}] <= bus.mem_data2;
            end
        end
    end

    assign bus.busy      = state != IDLE;
    assign bus.done      = state == DONE;
    assign bus.mem_load  = state == ISSUE;
    assign bus.mem_addr1 = bus.mem_load ? a1 : '0;
    assign bus.mem_addr2 = bus.mem_load ? a2 : '0;
    assign bus.win_valid = state == PRESENT;
    assign bus.win_last  = state == PRESENT && last;
    assign bus.win_row   = row;
    assign bus.win_col   = col;

    always_comb begin
        bus.win_data = '0;
        for (int k = 0; k < NT; k++) bus.win_data[k*DATA_W +: DATA_W] = taps[k];
    end
endmodule

// File: tb/tb_conv_window_fetch.sv
// tb_conv_window_fetch: directed self-checking bench for conv_window_fetch with a mem[i] = i mod 256 model
module tb_conv_window_fetch;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    conv_window_fetch_if bus ();
    conv_window_fetch dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_load) begin
            bus.mem_data1 <= bus.mem_addr1[7:0];
            bus.mem_data2 <= bus.mem_addr2[7:0];
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] exp_win(input int r, input int c);
        logic [71:0] w;
        w = '0;
        for (int kr = 0; kr < 3; kr++)
            for (int kc = 0; kc < 3; kc++)
                w[(kr*3+kc)*8 +: 8] = 8'((r + kr) * 28 + c + kc);
        return w;
    endfunction

    function automatic logic [127:0] all_outs();
        return {bus.busy, bus.done, bus.mem_load, bus.mem_addr1, bus.mem_addr2, bus.win_valid,
                bus.win_last, bus.win_data, bus.win_row, bus.win_col};
    endfunction

    // Runs an already-started pass to completion, checking every handshake in order.
    task automatic run_pass(input bit rnd);
        int er = 0, ec = 0, nhs = 0, ndone = 0;
        bit seen_done = 0, fin = 0;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            @(negedge clk);
            if (seen_done) begin
                chk("busy_fall", bus.busy, 0);
                fin = 1;
                break;
            end
            bus.win_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.start = rnd && bus.busy && !bus.done && (cyc % 397 == 50);
            if (bus.done) begin
                ndone++;
                chk("busy_at_done", bus.busy, 1);
                seen_done = 1;
            end
            if (bus.win_valid && bus.win_ready) begin
                chk("window", {bus.win_row, bus.win_col, bus.win_last, bus.win_data},
                    {5'(er), 5'(ec), 1'(er == 25 && ec == 25), exp_win(er, ec)});
                if (er == 0 && ec == 25)
                    chk("win_0_25", bus.win_data, 72'h53_52_51_37_36_35_1B_1A_19);
                if (er == 25 && ec == 25)
                    chk("win_25_25", bus.win_data, 72'h0F_0E_0D_F3_F2_F1_D7_D6_D5);
                nhs++;
                ec++;
                if (ec == 26) begin
                    ec = 0;
                    er++;
                end
            end
        end
        bus.start = 1'b0;
        chk("pass_finished", fin, 1);
        chk("handshakes", nhs, 676);
        chk("done_pulses", ndone, 1);
    endtask

    initial begin
        int first = 0, loads = 0, stable = 1;
        bit found = 0;
        logic [71:0] snap;
        bus.start = 1'b0;
        bus.win_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_zero", all_outs(), 0);
        rst = 1'b1;

        // first window latency and contents, then full pass with ready high
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int n = 1; n <= 12 && first == 0; n++) begin
            if (bus.mem_load) loads++;
            if (bus.win_valid) first = n;
            else @(negedge clk);
        end
        chk("first_valid_cycle", first, 7);
        chk("first_loads", loads, 5);
        chk("first_window", {bus.win_row, bus.win_col, bus.win_data},
            {5'd0, 5'd0, 72'h3A_39_38_1E_1D_1C_02_01_00});
        run_pass(1'b0);

        // backpressure on window (3,4)
        @(negedge clk);
        bus.win_ready = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int cyc = 0; cyc < 5000; cyc++) begin
            @(negedge clk);
            if (bus.win_valid && bus.win_row == 5'd3 && bus.win_col == 5'd4) begin
                bus.win_ready = 1'b0;
                found = 1;
                break;
            end
            bus.win_ready = 1'b1;
        end
        chk("stall_found", found, 1);
        snap = bus.win_data;
        chk("stall_window", snap, exp_win(3, 4));
        loads = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.mem_load) loads++;
            if (!bus.win_valid || bus.win_data !== snap) stable = 0;
        end
        chk("stall_stable", stable, 1);
        chk("stall_loads", loads, 0);
        bus.win_ready = 1'b1;
        found = 0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            @(negedge clk);
            if (bus.win_valid && !(bus.win_row == 5'd3 && bus.win_col == 5'd4)) begin
                found = 1;
                break;
            end
        end
        chk("after_stall", {found, bus.win_row, bus.win_col, bus.win_data},
            {1'b1, 5'd3, 5'd5, exp_win(3, 5)});
        rst = 1'b0;
        @(negedge clk);
        chk("reset_after_stall", all_outs(), 0);
        rst = 1'b1;

        // reset mid-ISSUE of window (10,10), with start asserted alongside it
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        found = 0;
        for (int cyc = 0; cyc < 5000; cyc++) begin
            @(negedge clk);
            bus.win_ready = 1'b1;
            if (bus.mem_load && bus.win_row == 5'd10 && bus.win_col == 5'd10) begin
                found = 1;
                break;
            end
        end
        chk("issue_10_10_found", found, 1);
        rst = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        chk("reset_mid_issue", all_outs(), 0);
        bus.start = 1'b0;
        rst = 1'b1;

        // restart from (0,0) with random ready and stray start pulses
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        run_pass(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
